// File: rtl/ysyx_24100027_branch_unit.sv
// ysyx_24100027_branch_unit
// Branch resolution (PC mux selects) plus a PC-indexed table of 2-bit
// saturating counters that predicts conditional branch direction for fetch.
// Resolved conditional branches train the table and raise a registered
// one-cycle mispredict pulse.
// Optional feature: define BRANCH_UNIT_STATS_EN to build the conditional /
// mispredict statistics counters; otherwise stat_cond and stat_miss are 0.
module ysyx_24100027_branch_unit #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [31:0]       res_pc,
    input  logic [2:0]        res_branch,
    input  logic              res_zero,
    input  logic              res_less,
    input  logic              res_pred_taken,
    input  logic              bht_flush,
    output logic              pc_a_sel,
    output logic              pc_b_sel,
    output logic              res_taken,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_cond,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       cnt_q [DEPTH];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             taken_raw;
    logic             cond;
    logic             mispredict_d;
    logic             mispredict_q;
    logic             unused_pc_bits;

    // Saturating 2-bit counter step towards the resolved direction.
    function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic t);
        logic [1:0] r;
        r = c;
        if (t) begin
            if (c != 2'b11) r = c + 2'b01;
        end else begin
            if (c != 2'b00) r = c - 2'b01;
        end
        return r;
    endfunction

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];

    // Byte offset and upper PC bits do not take part in indexing.
    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                              res_pc[31:IDX_W+2], res_pc[1:0]};

    // Prediction reads the current (pre-update) counter; no write bypass.
    assign pred_taken = cnt_q[pred_idx][1];

    // Decode the branch code against the ALU flags into direction and selects.
    always_comb begin
        taken_raw = 1'b0;
        case (res_branch)
            3'b001:  taken_raw = 1'b1;
            3'b010:  taken_raw = 1'b1;
            3'b100:  taken_raw = res_zero;
            3'b101:  taken_raw = ~res_zero;
            3'b110:  taken_raw = res_less;
            3'b111:  taken_raw = ~res_less;
            default: taken_raw = 1'b0;
        endcase
        res_taken    = res_valid & taken_raw;
        pc_a_sel     = res_taken;
        pc_b_sel     = res_valid & (res_branch == 3'b010);
        cond         = res_valid & res_branch[2];
        mispredict_d = cond & (res_taken != res_pred_taken);
    end

    // Counter table: reset/flush to CNT_INIT, otherwise train on conditional resolutions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
        end else if (bht_flush) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
        end else if (cond) begin
            cnt_q[res_idx] <= cnt_step(cnt_q[res_idx], res_taken);
        end
    end

    // One-cycle registered mispredict pulse for the redirect path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mispredict_q <= 1'b0;
        else        mispredict_q <= mispredict_d;
    end

    assign mispredict = mispredict_q;

`ifdef BRANCH_UNIT_STATS_EN
    logic [STAT_W-1:0] stat_cond_q;
    logic [STAT_W-1:0] stat_miss_q;
    logic [STAT_W-1:0] stat_cond_d;
    logic [STAT_W-1:0] stat_miss_d;

    // Next-state for the wrapping statistics counters.
    always_comb begin
        stat_cond_d = stat_cond_q;
        stat_miss_d = stat_miss_q;
        if (cond)         stat_cond_d = stat_cond_q + STAT_W'(1);
        if (mispredict_d) stat_miss_d = stat_miss_q + STAT_W'(1);
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cond_q <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_cond_q <= stat_cond_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_cond = stat_cond_q;
    assign stat_miss = stat_miss_q;
`else
    assign stat_cond = '0;
    assign stat_miss = '0;
`endif

endmodule

// File: doc/ysyx_24100027_branch_unit.md
# ysyx_24100027_branch_unit

Parametrised branch resolution and direction prediction unit for the NPC core. It resolves the 3-bit branch code against the ALU `zero`/`less` flags into the PC-A/PC-B mux selects. It also holds a table of 2-bit saturating counters, indexed by PC, that predicts conditional branch direction for fetch. Resolved outcomes train the table and raise a registered mispredict pulse used for redirect.

## Interface
Parameters:
- `IDX_W`, 6: table index width; the table holds 2^IDX_W counters.
- `CNT_INIT`, 2'b01: counter value after reset and after flush (weakly not-taken).
- `STAT_W`, 32: width of the statistics counters.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `pred_pc`  in  32  fetch PC to predict.
- `pred_taken`  out  1  combinational: bit 1 of the counter at `pred_pc[IDX_W+1:2]`.
- `res_valid`  in  1  a resolution is present this cycle.
- `res_pc`  in  32  PC of the resolving instruction.
- `res_branch`  in  3  branch code: 000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt(u), 111 bge(u).
- `res_zero`  in  1  ALU zero flag.
- `res_less`  in  1  ALU less flag.
- `res_pred_taken`  in  1  prediction carried down the pipe with the instruction.
- `bht_flush`  in  1  synchronous table re-initialisation.
- `pc_a_sel`  out  1  combinational: PC-A select (1 = imm).
- `pc_b_sel`  out  1  combinational: PC-B select (1 = rs1).
- `res_taken`  out  1  combinational: the resolved direction.
- `mispredict`  out  1  registered, one-cycle pulse.
- `stat_cond`  out  STAT_W  count of conditional branches resolved.
- `stat_miss`  out  STAT_W  count of mispredicts.

## Operation
- Taken decode:
  - 001 and 010: taken = 1.
  - 100: taken = `zero`.
  - 101: taken = `!zero`.
  - 110: taken = `less`.
  - 111: taken = `!less`.
  - 000 and 011: taken = 0.
- Mux selects:
  - `pc_a_sel` = taken.
  - `pc_b_sel` = 1 only for 010.
  - All selects are 0 when `res_valid` = 0.
- A resolution is conditional when `res_valid` = 1 and `res_branch[2]` = 1. Only conditional resolutions train the table, flag mispredicts or count.
- Training at index `res_pc[IDX_W+1:2]`:
  - Taken: the counter increments and saturates at 3.
  - Not taken: the counter decrements and saturates at 0.
- Mispredict is set on a conditional resolution where taken != `res_pred_taken`. jal/jalr never flag a mispredict.
- `bht_flush` sets every counter to `CNT_INIT` on the next edge and takes priority over any training in the same cycle. `mispredict` and the statistics counters still update in a flush cycle.
- Read/write collision: when the predict index equals the training index in the same cycle, `pred_taken` reflects the pre-update value. There is no bypass.

## Timing
- Decode outputs (`pc_a_sel`, `pc_b_sel`, `res_taken`) and `pred_taken` are zero-latency combinational.
- Table update is visible on `pred_taken` from the cycle after the resolution.
- `mispredict` is high during exactly the cycle after the resolving cycle. Back-to-back mispredicts give back-to-back pulses.
- Reset values:
  - All counters = `CNT_INIT`.
  - `mispredict` = 0.
  - `stat_cond` = `stat_miss` = 0.
  - Combinational outputs follow their inputs.
- Reset asserted mid-operation takes effect immediately and discards any pending pulse.

## Configuration
- `BRANCH_UNIT_STATS_EN`:
  - Defined: `stat_cond` increments by 1 per conditional resolution and `stat_miss` by 1 per mispredict. Both update registered, one cycle after the resolution, and wrap modulo 2^STAT_W.
  - Undefined: no counter flops exist and both ports are constant 0. The prediction, training and mispredict behaviour is identical.

## Test plan
- Reset release, `pred_pc` = 0x80000000 -> `pred_taken` = 0, all counters read 01, `mispredict` = 0.
- Decode sweep: code 101 with zero = 0 -> `pc_a_sel` = 1, `pc_b_sel` = 0. Code 010 -> `pc_a_sel` = 1, `pc_b_sel` = 1. Code 111 with less = 1 -> `pc_a_sel` = 0.
- Saturation: resolve beq taken at 0x80000010 four times, then predict 0x80000010 -> `pred_taken` = 1 and the counter holds 3. Two not-taken resolutions follow -> counter 1, `pred_taken` = 0.
- Mispredict: bne with zero = 0 and `res_pred_taken` = 0 -> `mispredict` = 1 in exactly the next cycle. jal with `res_pred_taken` = 0 -> no pulse.
- Collision and flush:
  - Train and predict the same index in one cycle -> old value seen, new value seen next cycle.
  - `bht_flush` together with a taken update -> counter = `CNT_INIT`.
- With `BRANCH_UNIT_STATS_EN`: 10 conditional resolutions including 3 mispredicts -> `stat_cond` = 10, `stat_miss` = 3. Preloading `stat_cond` to 2^STAT_W-1 and adding one resolution -> 0. Without the macro both ports stay 0.
